// File: rtl/datapath_ctrl_pkg.sv
// rtl/datapath_ctrl_pkg.sv - shared state, ALU/MU encodings and opcode constant (CTRL_MEXT_EN adds MUWAIT)
package datapath_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
`ifdef CTRL_MEXT_EN
        ST_MUWAIT,
`endif
        ST_WB,
        ST_TRAP
    } state_e;

    localparam logic [6:0] OP_R = 7'b0110011;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0011;
    localparam logic [3:0] ALU_SLTU = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b1000;
    localparam logic [3:0] ALU_AND  = 4'b1001;

    localparam logic [1:0] MUL_MUL    = 2'b00;
    localparam logic [1:0] MUL_MULH   = 2'b01;
    localparam logic [1:0] MUL_MULHSU = 2'b10;
    localparam logic [1:0] MUL_MULHU  = 2'b11;

endpackage

// File: rtl/datapath_ctrl_decode.sv
// rtl/datapath_ctrl_decode.sv - combinational R-type decode (MUL family legal only with CTRL_MEXT_EN)
module ctrl_decode
    import datapath_ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] func3_i,
    input  logic [1:0] func7b50_i,
    output logic [3:0] aluctl_o,
    output logic [1:0] mulctl_o,
    output logic       is_mu_o,
    output logic       legal_o
);

    always_comb begin
        aluctl_o = ALU_ADD;
        mulctl_o = MUL_MUL;
        is_mu_o  = 1'b0;
        legal_o  = 1'b0;
        if (opcode_i == OP_R) begin
            case (func7b50_i)
                2'b00: begin
                    legal_o = 1'b1;
                    case (func3_i)
                        3'b000:  aluctl_o = ALU_ADD;
                        3'b001:  aluctl_o = ALU_SLL;
                        3'b010:  aluctl_o = ALU_SLT;
                        3'b011:  aluctl_o = ALU_SLTU;
                        3'b100:  aluctl_o = ALU_XOR;
                        3'b101:  aluctl_o = ALU_SRL;
                        3'b110:  aluctl_o = ALU_OR;
                        default: aluctl_o = ALU_AND;
                    endcase
                end
                2'b10: begin
                    if (func3_i == 3'b000) begin
                        legal_o  = 1'b1;
                        aluctl_o = ALU_SUB;
                    end else if (func3_i == 3'b101) begin
                        legal_o  = 1'b1;
                        aluctl_o = ALU_SRA;
                    end
                end
`ifdef CTRL_MEXT_EN
                2'b01: begin
                    if (!func3_i[2]) begin
                        legal_o  = 1'b1;
                        is_mu_o  = 1'b1;
                        mulctl_o = func3_i[1:0];
                    end
                end
`endif
                default: legal_o = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/datapath_ctrl.sv
// rtl/datapath_ctrl.sv - multi-cycle issue controller FSM; CTRL_MEXT_EN enables the MUL family and MUWAIT
module datapath_ctrl
    import datapath_ctrl_pkg::*;
#(
    parameter int PCMUX_N  = 2,
    parameter int IFURES_N = 2,
    localparam int PCW = (PCMUX_N > 1) ? $clog2(PCMUX_N) : 1,
    localparam int IFW = (IFURES_N > 1) ? $clog2(IFURES_N) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           run,
    input  logic [6:0]     opcode,
    input  logic [2:0]     func3,
    input  logic [1:0]     func7b50,
    input  logic           exdone,
    output logic [PCW-1:0] pcmuxctl,
    output logic           pcnextctl,
    output logic           instrre,
    output logic           regre,
    output logic           regwe,
    output logic           mulstart,
    output logic [3:0]     aluctl,
    output logic [1:0]     mulctl,
    output logic [IFW-1:0] ifuresctl,
    output logic           busy,
    output logic           illegal,
    output logic [31:0]    instret
);

    state_e      state_q;
    logic        instrre_q, regre_q, regwe_q, pcnext_q, illegal_q;
    logic [3:0]  aluctl_q;
    logic [1:0]  mulctl_q;
    logic [31:0] instret_q, instret_d;

    logic [3:0]  dec_aluctl;
    logic [1:0]  dec_mulctl;
    logic        dec_is_mu, dec_legal;

    ctrl_decode u_decode (
        .opcode_i   (opcode),
        .func3_i    (func3),
        .func7b50_i (func7b50),
        .aluctl_o   (dec_aluctl),
        .mulctl_o   (dec_mulctl),
        .is_mu_o    (dec_is_mu),
        .legal_o    (dec_legal)
    );

`ifdef CTRL_MEXT_EN
    logic           mulstart_q;
    logic [IFW-1:0] ifuresctl_q;
`else
    logic unused_inputs;
    assign unused_inputs = dec_is_mu | exdone;
`endif

    always_comb begin
        instret_d = instret_q;
        if (state_q == ST_WB) begin
            instret_d = instret_q + 32'd1;
        end
    end

    // Strobes are cleared every cycle and set only on entry to the state that owns them.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            instrre_q   <= 1'b0;
            regre_q     <= 1'b0;
            regwe_q     <= 1'b0;
            pcnext_q    <= 1'b0;
            illegal_q   <= 1'b0;
            aluctl_q    <= ALU_ADD;
            mulctl_q    <= MUL_MUL;
            instret_q   <= 32'd0;
`ifdef CTRL_MEXT_EN
            mulstart_q  <= 1'b0;
            ifuresctl_q <= '0;
`endif
        end else begin
            instret_q <= instret_d;
            instrre_q <= 1'b0;
            regre_q   <= 1'b0;
            regwe_q   <= 1'b0;
            pcnext_q  <= 1'b0;
`ifdef CTRL_MEXT_EN
            mulstart_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (run) begin
                        state_q   <= ST_FETCH;
                        instrre_q <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    state_q <= ST_DECODE;
                    regre_q <= 1'b1;
                end
                ST_DECODE: begin
                    aluctl_q <= dec_aluctl;
                    mulctl_q <= dec_mulctl;
`ifdef CTRL_MEXT_EN
                    ifuresctl_q <= IFW'(dec_is_mu);
`endif
                    if (!dec_legal) begin
                        state_q   <= ST_TRAP;
                        illegal_q <= 1'b1;
                    end else begin
                        state_q <= ST_EXEC;
`ifdef CTRL_MEXT_EN
                        mulstart_q <= dec_is_mu;
`endif
                    end
                end
                ST_EXEC: begin
`ifdef CTRL_MEXT_EN
                    if (ifuresctl_q != '0) begin
                        state_q <= ST_MUWAIT;
                    end else
`endif
                    begin
                        state_q  <= ST_WB;
                        regwe_q  <= 1'b1;
                        pcnext_q <= 1'b1;
                    end
                end
`ifdef CTRL_MEXT_EN
                ST_MUWAIT: begin
                    if (exdone) begin
                        state_q  <= ST_WB;
                        regwe_q  <= 1'b1;
                        pcnext_q <= 1'b1;
                    end
                end
`endif
                ST_WB: begin
                    if (run) begin
                        state_q   <= ST_FETCH;
                        instrre_q <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_TRAP: state_q <= ST_TRAP;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign pcmuxctl  = '0;
    assign pcnextctl = pcnext_q;
    assign instrre   = instrre_q;
    assign regre     = regre_q;
    assign regwe     = regwe_q;
    assign aluctl    = aluctl_q;
    assign mulctl    = mulctl_q;
    assign busy      = (state_q != ST_IDLE) && (state_q != ST_TRAP);
    assign illegal   = illegal_q;
    assign instret   = instret_q;
`ifdef CTRL_MEXT_EN
    assign mulstart  = mulstart_q;
    assign ifuresctl = ifuresctl_q;
`else
    assign mulstart  = 1'b0;
    assign ifuresctl = '0;
`endif

endmodule

// File: tb/tb_datapath_ctrl.sv
// tb/tb_datapath_ctrl.sv - self-checking bench for datapath_ctrl (expectations follow CTRL_MEXT_EN)
module tb_datapath_ctrl;

`ifdef CTRL_MEXT_EN
    localparam bit MEXT = 1'b1;
`else
    localparam bit MEXT = 1'b0;
`endif

    logic        clk, rst, run, exdone;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [1:0]  func7b50;
    logic [0:0]  pcmuxctl;
    logic        pcnextctl, instrre, regre, regwe, mulstart, busy, illegal;
    logic [3:0]  aluctl;
    logic [1:0]  mulctl;
    logic [0:0]  ifuresctl;
    logic [31:0] instret;

    datapath_ctrl dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode), .func3(func3),
        .func7b50(func7b50), .exdone(exdone), .pcmuxctl(pcmuxctl),
        .pcnextctl(pcnextctl), .instrre(instrre), .regre(regre), .regwe(regwe),
        .mulstart(mulstart), .aluctl(aluctl), .mulctl(mulctl),
        .ifuresctl(ifuresctl), .busy(busy), .illegal(illegal), .instret(instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [6:0] op;
        logic [2:0] f3;
        logic [1:0] f7;
        bit         trap;
        bit         mu;
        logic [3:0] alu;
        logic [1:0] mul;
        logic       ifu;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; exdone = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic add_vec(input string name, input logic [6:0] op, input logic [2:0] f3,
                           input logic [1:0] f7, input bit trap, input bit mu,
                           input logic [3:0] alu, input logic [1:0] mul, input logic ifu);
        vec_t v;
        v.name = name; v.op = op; v.f3 = f3; v.f7 = f7; v.trap = trap;
        v.mu = mu; v.alu = alu; v.mul = mul; v.ifu = ifu;
        vecs.push_back(v);
    endtask

    // Bit c of each mask records the strobe seen in cycle c after issue.
    task automatic run_cycles(input int n, input int drop_run, input int exd_from,
                              output logic [31:0] m_ir, output logic [31:0] m_rr,
                              output logic [31:0] m_we, output logic [31:0] m_pc,
                              output logic [31:0] m_ms);
        m_ir = '0; m_rr = '0; m_we = '0; m_pc = '0; m_ms = '0;
        for (int c = 1; c <= n; c++) begin
            tick();
            if (c == drop_run) run = 1'b0;
            exdone = (exd_from != 0) && (c >= exd_from);
            if (instrre)   m_ir[c] = 1'b1;
            if (regre)     m_rr[c] = 1'b1;
            if (regwe)     m_we[c] = 1'b1;
            if (pcnextctl) m_pc[c] = 1'b1;
            if (mulstart)  m_ms[c] = 1'b1;
        end
        exdone = 1'b0;
    endtask

    task automatic chk_idle_reset(input string tag);
        chk({tag, " instrre"},   32'(instrre),   32'd0);
        chk({tag, " regre"},     32'(regre),     32'd0);
        chk({tag, " regwe"},     32'(regwe),     32'd0);
        chk({tag, " pcnext"},    32'(pcnextctl), 32'd0);
        chk({tag, " mulstart"},  32'(mulstart),  32'd0);
        chk({tag, " busy"},      32'(busy),      32'd0);
        chk({tag, " illegal"},   32'(illegal),   32'd0);
        chk({tag, " instret"},   instret,        32'd0);
        chk({tag, " aluctl"},    32'(aluctl),    32'd0);
        chk({tag, " mulctl"},    32'(mulctl),    32'd0);
        chk({tag, " ifuresctl"}, 32'(ifuresctl), 32'd0);
        chk({tag, " pcmuxctl"},  32'(pcmuxctl),  32'd0);
    endtask

    initial begin
        logic [31:0] m_ir, m_rr, m_we, m_pc, m_ms, exp_we;
        vec_t v, e;

        rst = 1'b1; run = 1'b0; exdone = 1'b0;
        opcode = '0; func3 = '0; func7b50 = '0;

        add_vec("ADD",   7'h33, 3'b000, 2'b00, 1'b0, 1'b0, 4'b0000, 2'b00, 1'b0);
        add_vec("SLL",   7'h33, 3'b001, 2'b00, 1'b0, 1'b0, 4'b0010, 2'b00, 1'b0);
        add_vec("SLT",   7'h33, 3'b010, 2'b00, 1'b0, 1'b0, 4'b0011, 2'b00, 1'b0);
        add_vec("SLTU",  7'h33, 3'b011, 2'b00, 1'b0, 1'b0, 4'b0100, 2'b00, 1'b0);
        add_vec("XOR",   7'h33, 3'b100, 2'b00, 1'b0, 1'b0, 4'b0101, 2'b00, 1'b0);
        add_vec("SRL",   7'h33, 3'b101, 2'b00, 1'b0, 1'b0, 4'b0110, 2'b00, 1'b0);
        add_vec("OR",    7'h33, 3'b110, 2'b00, 1'b0, 1'b0, 4'b1000, 2'b00, 1'b0);
        add_vec("AND",   7'h33, 3'b111, 2'b00, 1'b0, 1'b0, 4'b1001, 2'b00, 1'b0);
        add_vec("SUB",   7'h33, 3'b000, 2'b10, 1'b0, 1'b0, 4'b0001, 2'b00, 1'b0);
        add_vec("SRA",   7'h33, 3'b101, 2'b10, 1'b0, 1'b0, 4'b0111, 2'b00, 1'b0);
        add_vec("F7_10_001", 7'h33, 3'b001, 2'b10, 1'b1, 1'b0, 4'b0000, 2'b00, 1'b0);
        add_vec("F7_11",     7'h33, 3'b000, 2'b11, 1'b1, 1'b0, 4'b0000, 2'b00, 1'b0);
        add_vec("MULHU", 7'h33, 3'b011, 2'b01, !MEXT, MEXT, 4'b0000, 2'b11, 1'b1);
        add_vec("MUL",   7'h33, 3'b000, 2'b01, !MEXT, MEXT, 4'b0000, 2'b00, 1'b1);
        add_vec("DIV",   7'h33, 3'b100, 2'b01, 1'b1, 1'b0, 4'b0000, 2'b00, 1'b0);
        add_vec("OPIMM", 7'h13, 3'b000, 2'b00, 1'b1, 1'b0, 4'b0000, 2'b00, 1'b0);

        do_reset();
        chk_idle_reset("reset");

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            do_reset();
            opcode = v.op; func3 = v.f3; func7b50 = v.f7; run = 1'b1;
            sb.push_back(v);
            run_cycles(30, 1, v.mu ? 9 : 0, m_ir, m_rr, m_we, m_pc, m_ms);
            e = sb.pop_front();
            exp_we = e.trap ? 32'h0 : (e.mu ? 32'h400 : 32'h10);
            chk({e.name, " instrre"},  m_ir, 32'h2);
            chk({e.name, " regre"},    m_rr, 32'h4);
            chk({e.name, " regwe"},    m_we, exp_we);
            chk({e.name, " pcnext"},   m_pc, exp_we);
            chk({e.name, " mulstart"}, m_ms, e.mu ? 32'h8 : 32'h0);
            chk({e.name, " illegal"},  32'(illegal), 32'(e.trap));
            chk({e.name, " busy"},     32'(busy), 32'd0);
            chk({e.name, " instret"},  instret, e.trap ? 32'd0 : 32'd1);
            if (!e.trap) begin
                chk({e.name, " aluctl"},    32'(aluctl),    32'(e.alu));
                chk({e.name, " mulctl"},    32'(mulctl),    32'(e.mul));
                chk({e.name, " ifuresctl"}, 32'(ifuresctl), 32'(e.ifu));
            end
        end

        // The last table entry trapped; reset must clear the sticky flag.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("trap_clear illegal", 32'(illegal), 32'd0);
        chk("trap_clear busy",    32'(busy),    32'd0);

        // Back-to-back issue with run held through the first WB.
        do_reset();
        opcode = 7'h33; func3 = 3'b000; func7b50 = 2'b00; run = 1'b1;
        run_cycles(14, 5, 0, m_ir, m_rr, m_we, m_pc, m_ms);
        chk("b2b instrre", m_ir, 32'h22);
        chk("b2b regwe",   m_we, 32'h110);
        chk("b2b instret", instret, 32'd2);
        chk("b2b busy",    32'(busy), 32'd0);

        // Reset mid-instruction (MUWAIT with the M extension, EXEC otherwise).
        do_reset();
        opcode = 7'h33; func3 = 3'b000; func7b50 = 2'b00; run = 1'b1;
        run_cycles(8, 1, 0, m_ir, m_rr, m_we, m_pc, m_ms);
        chk("midrst pre instret", instret, 32'd1);
        func3 = MEXT ? 3'b011 : 3'b101;
        func7b50 = MEXT ? 2'b01 : 2'b10;
        run = 1'b1;
        run_cycles(MEXT ? 5 : 3, 1, 0, m_ir, m_rr, m_we, m_pc, m_ms);
        chk("midrst busy before", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle_reset("midrst");

        // instret wrap: preset to all-ones while idle, then retire one instruction.
        do_reset();
        force dut.instret_q = 32'hFFFF_FFFF;
        tick();
        release dut.instret_q;
        tick();
        chk("wrap preset", instret, 32'hFFFF_FFFF);
        opcode = 7'h33; func3 = 3'b100; func7b50 = 2'b00; run = 1'b1;
        run_cycles(10, 1, 0, m_ir, m_rr, m_we, m_pc, m_ms);
        chk("wrap regwe",   m_we, 32'h10);
        chk("wrap instret", instret, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/datapath_ctrl.md
DATAPATH_CTRL -- requirements
Module: datapath_ctrl

Interface
REQ-001 SHALL have parameter PCMUX_N, default 2, pc mux input count; pcmuxctl width is clog2(PCMUX_N).
REQ-002 SHALL have parameter IFURES_N, default 2, IFU result mux input count; ifuresctl width is clog2(IFURES_N).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- run  in  1  allow instruction issue
- opcode  in  7  instr[6:0]
- func3  in  3  instr[14:12]
- func7b50  in  2  {instr[30],instr[25]}
- exdone  in  1  EX-stage done
- pcmuxctl  out  clog2(PCMUX_N)  pc source select
- pcnextctl  out  1  pc update strobe
- instrre  out  1  instruction read enable
- regre  out  1  regfile read enable
- regwe  out  1  regfile write enable
- mulstart  out  1  MU start pulse
- aluctl  out  4  ALU op
- mulctl  out  2  MU op
- ifuresctl  out  clog2(IFURES_N)  0=ALU, 1=MU
- busy  out  1  state not IDLE/TRAP
- illegal  out  1  sticky illegal-instruction flag
- instret  out  32  retired-instruction count

Function
REQ-005 SHALL implement FSM states IDLE, FETCH, DECODE, EXEC, MUWAIT, WB, TRAP.
REQ-006 IDLE->FETCH when run=1; otherwise SHALL stay in IDLE.
REQ-007 FETCH SHALL assert instrre for one cycle, then go to DECODE.
REQ-008 DECODE SHALL assert regre, decode opcode/func3/func7b50, and latch aluctl/mulctl/ifuresctl into registers held until the next DECODE.
REQ-009 Legal set SHALL be opcode 7'b0110011 with func7b50=00 (any func3), func7b50=10 with func3 000 (SUB) or 101 (SRA), and func7b50=01 with func3[2]=0 (MUL family); all else SHALL go DECODE->TRAP.
REQ-010 aluctl encoding: ADD 0000, SUB 0001, SLL 0010, SLT 0011, SLTU 0100, XOR 0101, SRL 0110, SRA 0111, OR 1000, AND 1001.
REQ-011 MUL-family: mulctl=func3[1:0], ifuresctl=1; all others: ifuresctl=0, mulctl=00.
REQ-012 EXEC for an ALU op SHALL go to WB next cycle; for an MU op SHALL pulse mulstart for exactly one cycle and go to MUWAIT.
REQ-013 exdone SHALL be sampled only in MUWAIT; MUWAIT->WB on exdone=1, with no timeout.
REQ-014 WB SHALL assert regwe and pcnextctl for one cycle with pcmuxctl=0 (pc+4), increment instret (wrapping 0xFFFFFFFF->0), then go to FETCH if run=1, else IDLE.
REQ-015 run deassertion mid-instruction SHALL NOT abort; the current instruction completes first.
REQ-016 TRAP SHALL set illegal=1 and hold all strobes at 0 until rst; pc is not advanced.
REQ-017 Strobes (instrre, regre, regwe, pcnextctl, mulstart) SHALL be Moore outputs of the registered state; latency is ALU 4 cycles, MU 4+N cycles (N = MUWAIT cycles).

Reset
REQ-018 rst SHALL force, on the next edge, state=IDLE, all strobes 0, pcmuxctl=0, aluctl=0000, mulctl=00, ifuresctl=0, illegal=0, instret=0, regardless of current state.

Configuration
REQ-019 With CTRL_MEXT_EN defined, the MUL family SHALL be legal per REQ-009/011.
REQ-020 Without CTRL_MEXT_EN, func7b50=01 SHALL be illegal (TRAP), the MUWAIT state SHALL be absent, and mulstart and ifuresctl SHALL be tied to 0.

Structure
REQ-021 A shared package SHALL hold the state enum, the aluctl encodings, the mulctl encodings, and the OP_R=7'b0110011 constant.
REQ-022 One sub-module, ctrl_decode (combinational opcode/func -> aluctl/mulctl/ifuresctl/legal), SHALL be instantiated by datapath_ctrl.

Verification
REQ-023 ADD (0x33, func3=000, f7=00), run=1 -> instrre cycle1, regre cycle2, regwe+pcnextctl cycle4, aluctl=0000, instret 0->1.
REQ-024 SUB (f7=10, func3=000) -> aluctl=0001, ifuresctl=0; SRA (f7=10, func3=101) -> aluctl=0111.
REQ-025 MULHU (f7=01, func3=011), exdone raised after 5 MUWAIT cycles -> one mulstart pulse, mulctl=11, ifuresctl=1, regwe in the cycle after exdone; without CTRL_MEXT_EN -> TRAP, illegal=1.
REQ-026 opcode 0x13 -> TRAP, illegal=1, no regwe/pcnextctl ever; rst -> illegal=0, IDLE.
REQ-027 rst asserted in MUWAIT -> next cycle IDLE, all strobes 0, instret=0; run dropped during EXEC -> WB completes, then IDLE with busy=0.
REQ-028 instret preset to 0xFFFFFFFF via 2^32-1 retirements (forced) -> next WB wraps it to 0.
